// File: rtl/hazard_fwd_if.sv
// Pipeline-side bundle for the hazard/forwarding controller: register fields and
// memory status in, forwarding selects, hold/bubble controls and counters out.
interface hazard_fwd_if #(
  parameter int AW    = 4,
  parameter int CNT_W = 16
);
  logic [AW-1:0]    id_rs, id_rt;
  logic             id_rs_used, id_rt_used, id_jr;
  logic [AW-1:0]    id_ex_rs, id_ex_rt, id_ex_rd;
  logic             id_ex_rw, id_ex_memrd;
  logic [AW-1:0]    ex_mem_rd;
  logic             ex_mem_rw, ex_mem_memrd;
  logic [AW-1:0]    mem_wb_rd;
  logic             mem_wb_rw;
  logic             dmem_busy;
  logic             cnt_clr;

  logic [1:0]       forwarda, forwardb, forward_jr;
  logic             stall_pc, stall_ifid, bubble_idex, freeze_all;
  logic [CNT_W-1:0] stall_cnt, freeze_cnt;

  // Pipeline side: drives register fields, observes controls.
  modport master (
    output id_rs, id_rt, id_rs_used, id_rt_used, id_jr,
           id_ex_rs, id_ex_rt, id_ex_rd, id_ex_rw, id_ex_memrd,
           ex_mem_rd, ex_mem_rw, ex_mem_memrd, mem_wb_rd, mem_wb_rw,
           dmem_busy, cnt_clr,
    input  forwarda, forwardb, forward_jr, stall_pc, stall_ifid,
           bubble_idex, freeze_all, stall_cnt, freeze_cnt
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_rs_used, id_rt_used, id_jr,
           id_ex_rs, id_ex_rt, id_ex_rd, id_ex_rw, id_ex_memrd,
           ex_mem_rd, ex_mem_rw, ex_mem_memrd, mem_wb_rd, mem_wb_rw,
           dmem_busy, cnt_clr,
    output forwarda, forwardb, forward_jr, stall_pc, stall_ifid,
           bubble_idex, freeze_all, stall_cnt, freeze_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding for the 5-stage pipeline: ALU/JR forwarding,
// load-use stall FSM, data-memory freeze and saturating stall/freeze counters.
module hazard_fwd_unit #(
  parameter int AW       = 4,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_fwd_if.slave  bus
);

  localparam int CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  typedef enum logic {RUN = 1'b0, LD_STALL = 1'b1} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [CNT_W-1:0] stall_cnt_q, freeze_cnt_q;

  function automatic logic dst_valid(input logic [AW-1:0] rd, input logic rw);
    return rw && ((ZERO_REG == 0) || (rd != '0));
  endfunction

  // EX/MEM wins over MEM/WB; a load still in EX/MEM has no data to forward yet.
  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                         input logic ex_ok, input logic ex_ld,
                                         input logic [AW-1:0] ex_rd,
                                         input logic wb_ok,
                                         input logic [AW-1:0] wb_rd);
    if (ex_ok && !ex_ld && ex_rd == src) return 2'b10;
    if (wb_ok && wb_rd == src)           return 2'b01;
    return 2'b00;
  endfunction

  logic       idex_ok, exmem_ok, memwb_ok;
  logic       lu_haz, jr_haz, stall, freeze, hold;
  logic [1:0] fa, fb, fj;

  assign idex_ok  = dst_valid(bus.id_ex_rd,  bus.id_ex_rw);
  assign exmem_ok = dst_valid(bus.ex_mem_rd, bus.ex_mem_rw);
  assign memwb_ok = dst_valid(bus.mem_wb_rd, bus.mem_wb_rw);

  assign fa = fwd_sel(bus.id_ex_rs, exmem_ok, bus.ex_mem_memrd, bus.ex_mem_rd,
                      memwb_ok, bus.mem_wb_rd);
  assign fb = fwd_sel(bus.id_ex_rt, exmem_ok, bus.ex_mem_memrd, bus.ex_mem_rd,
                      memwb_ok, bus.mem_wb_rd);
  assign fj = bus.id_jr ? fwd_sel(bus.id_rs, exmem_ok, bus.ex_mem_memrd, bus.ex_mem_rd,
                                  memwb_ok, bus.mem_wb_rd)
                        : 2'b00;

  assign lu_haz = idex_ok && bus.id_ex_memrd &&
                  ((bus.id_rs_used && bus.id_ex_rd == bus.id_rs) ||
                   (bus.id_rt_used && bus.id_ex_rd == bus.id_rt));

  assign jr_haz = bus.id_jr &&
                  ((idex_ok && bus.id_ex_rd == bus.id_rs) ||
                   (exmem_ok && bus.ex_mem_memrd && bus.ex_mem_rd == bus.id_rs));

  assign freeze = bus.dmem_busy && rst_n;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    case (state)
      RUN: begin
        stall = lu_haz || jr_haz;
        if (lu_haz && LOAD_LAT > 1) begin
          state_n = LD_STALL;
          cnt_n   = CW'(LOAD_LAT - 1);
        end
      end
      LD_STALL: begin
        stall = 1'b1;
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
    // A busy data memory freezes the stall sequence where it stands.
    if (freeze) begin
      state_n = state;
      cnt_n   = cnt;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  assign hold = stall && !freeze && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      stall_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (hold && stall_cnt_q != '1)    stall_cnt_q  <= stall_cnt_q + CNT_W'(1);
      if (freeze && freeze_cnt_q != '1) freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
    end
  end

  // Outputs are forced quiet while reset is held, even mid-stall.
  assign bus.forwarda    = rst_n ? fa : 2'b00;
  assign bus.forwardb    = rst_n ? fb : 2'b00;
  assign bus.forward_jr  = rst_n ? fj : 2'b00;
  assign bus.stall_pc    = hold;
  assign bus.stall_ifid  = hold;
  assign bus.bubble_idex = hold;
  assign bus.freeze_all  = freeze;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.freeze_cnt  = freeze_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: a LOAD_LAT=1/CNT_W=4 instance and a
// LOAD_LAT=3/CNT_W=16 instance, each driven through its own interface.
module tb_hazard_fwd_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   sc1;

  always #5 clk = ~clk;

  hazard_fwd_if #(.AW(4), .CNT_W(4))  f1 ();
  hazard_fwd_if #(.AW(4), .CNT_W(16)) f3 ();

  hazard_fwd_unit #(.AW(4), .LOAD_LAT(1), .ZERO_REG(1), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(f1.slave));

  hazard_fwd_unit #(.AW(4), .LOAD_LAT(3), .ZERO_REG(1), .CNT_W(16)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(f3.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    f1.id_rs = 0; f1.id_rt = 0; f1.id_rs_used = 0; f1.id_rt_used = 0; f1.id_jr = 0;
    f1.id_ex_rs = 0; f1.id_ex_rt = 0; f1.id_ex_rd = 0; f1.id_ex_rw = 0; f1.id_ex_memrd = 0;
    f1.ex_mem_rd = 0; f1.ex_mem_rw = 0; f1.ex_mem_memrd = 0; f1.mem_wb_rd = 0; f1.mem_wb_rw = 0;
    f1.dmem_busy = 0; f1.cnt_clr = 0;
    f3.id_rs = 0; f3.id_rt = 0; f3.id_rs_used = 0; f3.id_rt_used = 0; f3.id_jr = 0;
    f3.id_ex_rs = 0; f3.id_ex_rt = 0; f3.id_ex_rd = 0; f3.id_ex_rw = 0; f3.id_ex_memrd = 0;
    f3.ex_mem_rd = 0; f3.ex_mem_rw = 0; f3.ex_mem_memrd = 0; f3.mem_wb_rd = 0; f3.mem_wb_rw = 0;
    f3.dmem_busy = 0; f3.cnt_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sc1      = 0;
    rst_n    = 1'b0;
    idle();

    // Reset: live hazard/forward conditions must be masked.
    f1.id_ex_rs = 3; f1.ex_mem_rd = 3; f1.ex_mem_rw = 1; f1.dmem_busy = 1;
    f1.id_ex_rd = 3; f1.id_ex_rw = 1; f1.id_ex_memrd = 1; f1.id_rs = 3; f1.id_rs_used = 1;
    settle();
    check("rst_fa",  32'(f1.forwarda), 0);
    check("rst_bub", 32'(f1.bubble_idex), 0);
    check("rst_frz", 32'(f1.freeze_all), 0);
    check("rst_sc1", 32'(f1.stall_cnt), 0);
    check("rst_fc1", 32'(f1.freeze_cnt), 0);
    check("rst_sc3", 32'(f3.stall_cnt), 0);
    tick(); idle(); rst_n = 1'b1;

    // Forwarding priority and ZERO_REG masking.
    f1.id_ex_rs = 3; f1.id_ex_rt = 3; f1.ex_mem_rd = 3; f1.ex_mem_rw = 1;
    f1.mem_wb_rd = 3; f1.mem_wb_rw = 1; f1.id_rs = 3;
    settle();
    check("fa_exmem", 32'(f1.forwarda), 2);
    check("fb_exmem", 32'(f1.forwardb), 2);
    check("fjr_nojr", 32'(f1.forward_jr), 0);
    check("fwd_nobub", 32'(f1.bubble_idex), 0);
    tick(); f1.ex_mem_rd = 0;
    settle();
    check("fa_memwb", 32'(f1.forwarda), 1);
    check("fb_memwb", 32'(f1.forwardb), 1);
    tick(); f1.ex_mem_rd = 3; f1.ex_mem_memrd = 1;
    settle();
    check("fa_ld_exmem", 32'(f1.forwarda), 1);
    tick(); idle();
    f1.ex_mem_rw = 1; f1.mem_wb_rw = 1; f1.id_ex_rw = 1; f1.id_ex_memrd = 1;
    f1.id_rs_used = 1;
    settle();
    check("fa_zero", 32'(f1.forwarda), 0);
    check("lu_zero", 32'(f1.bubble_idex), 0);
    tick(); idle();

    // Load-use, LOAD_LAT=1: one bubble, then MEM/WB forward.
    f1.id_ex_rd = 5; f1.id_ex_rw = 1; f1.id_ex_memrd = 1; f1.id_rt = 5; f1.id_rt_used = 1;
    settle();
    check("lu1_pc",   32'(f1.stall_pc), 1);
    check("lu1_ifid", 32'(f1.stall_ifid), 1);
    check("lu1_bub",  32'(f1.bubble_idex), 1);
    tick(); idle(); sc1 = 1;
    f1.id_ex_rt = 5; f1.id_ex_rd = 6; f1.id_ex_rw = 1; f1.mem_wb_rd = 5; f1.mem_wb_rw = 1;
    settle();
    check("lu1_fb",   32'(f1.forwardb), 1);
    check("lu1_done", 32'(f1.bubble_idex), 0);
    check("lu1_sc",   32'(f1.stall_cnt), 32'(sc1));
    tick(); idle();

    // Load-use, LOAD_LAT=3 with a 2-cycle freeze in the middle.
    f3.id_ex_rd = 5; f3.id_ex_rw = 1; f3.id_ex_memrd = 1; f3.id_rt = 5; f3.id_rt_used = 1;
    settle(); check("lu3_b1", 32'(f3.bubble_idex), 1);
    tick(); settle(); check("lu3_b2", 32'(f3.bubble_idex), 1);
    tick(); f3.dmem_busy = 1;
    settle();
    check("lu3_frz1", 32'(f3.freeze_all), 1);
    check("lu3_fbub1", 32'(f3.bubble_idex), 0);
    tick(); settle();
    check("lu3_frz2", 32'(f3.freeze_all), 1);
    check("lu3_fpc2", 32'(f3.stall_pc), 0);
    tick(); f3.dmem_busy = 0;
    settle();
    check("lu3_b3", 32'(f3.bubble_idex), 1);
    check("lu3_nofrz", 32'(f3.freeze_all), 0);
    tick(); idle();
    settle();
    check("lu3_end", 32'(f3.bubble_idex), 0);
    check("lu3_sc",  32'(f3.stall_cnt), 3);
    check("lu3_fc",  32'(f3.freeze_cnt), 2);
    tick(); idle();

    // JR behind an ALU producer, then EX/MEM forward.
    f1.id_jr = 1; f1.id_rs = 7; f1.id_rs_used = 1; f1.id_ex_rd = 7; f1.id_ex_rw = 1;
    settle();
    check("jr_stall", 32'(f1.stall_pc), 1);
    tick(); sc1 = sc1 + 1;
    f1.id_ex_rw = 0; f1.ex_mem_rd = 7; f1.ex_mem_rw = 1;
    settle();
    check("jr_fwd10", 32'(f1.forward_jr), 2);
    check("jr_nostall", 32'(f1.stall_pc), 0);
    tick(); idle();

    // JR behind a load: stall while load is in ID/EX and EX/MEM, then MEM/WB forward.
    f1.id_jr = 1; f1.id_rs = 7; f1.id_rs_used = 1;
    f1.id_ex_rd = 7; f1.id_ex_rw = 1; f1.id_ex_memrd = 1;
    settle(); check("jrld_s1", 32'(f1.bubble_idex), 1);
    tick(); sc1 = sc1 + 1;
    f1.id_ex_rw = 0; f1.id_ex_memrd = 0; f1.ex_mem_rd = 7; f1.ex_mem_rw = 1; f1.ex_mem_memrd = 1;
    settle();
    check("jrld_s2", 32'(f1.bubble_idex), 1);
    check("jrld_fj00", 32'(f1.forward_jr), 0);
    tick(); sc1 = sc1 + 1;
    f1.ex_mem_rw = 0; f1.ex_mem_memrd = 0; f1.mem_wb_rd = 7; f1.mem_wb_rw = 1;
    settle();
    check("jrld_fj01", 32'(f1.forward_jr), 1);
    check("jrld_go", 32'(f1.bubble_idex), 0);
    check("jrld_sc", 32'(f1.stall_cnt), 32'(sc1));
    tick(); idle();

    // Saturation at 15 (CNT_W=4), then clear wins over increment.
    f1.id_jr = 1; f1.id_rs = 7; f1.id_ex_rd = 7; f1.id_ex_rw = 1;
    repeat (15 - sc1 + 2) tick();
    settle();
    check("sat_sc", 32'(f1.stall_cnt), 15);
    f1.cnt_clr = 1;
    settle();
    check("clr_bub", 32'(f1.bubble_idex), 1);
    tick(); idle();
    settle();
    check("clr_sc", 32'(f1.stall_cnt), 0);
    tick(); idle();

    // Asynchronous reset in the middle of a LOAD_LAT=3 stall.
    f3.id_ex_rd = 5; f3.id_ex_rw = 1; f3.id_ex_memrd = 1; f3.id_rt = 5; f3.id_rt_used = 1;
    f3.id_ex_rs = 3; f3.ex_mem_rd = 3; f3.ex_mem_rw = 1;
    tick(); settle();
    check("mid_bub", 32'(f3.bubble_idex), 1);
    f3.dmem_busy = 1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_bub", 32'(f3.bubble_idex), 0);
    check("arst_pc",  32'(f3.stall_pc), 0);
    check("arst_frz", 32'(f3.freeze_all), 0);
    check("arst_fa",  32'(f3.forwarda), 0);
    check("arst_sc",  32'(f3.stall_cnt), 0);
    tick(); idle(); rst_n = 1'b1;
    settle();
    check("rel_bub1", 32'(f3.bubble_idex), 0);
    tick(); settle();
    check("rel_bub2", 32'(f3.bubble_idex), 0);
    check("rel_sc",   32'(f3.stall_cnt), 0);
    check("rel_fc",   32'(f3.freeze_cnt), 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
